// File: rtl/micro_div_pkg.sv
// Shared widths, FSM state codes and constants for the micro_div restoring divider tile.
package micro_div_pkg;

  localparam int unsigned DVD_W  = 8;
  localparam int unsigned DVS_W  = 4;
  localparam int unsigned N_ITER = 8;

  localparam logic [7:0] DBZ_QUOT = 8'hFF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DBZ  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/micro_div_core.sv
// Restoring divider core: start edge detect, FSM, R/Q/D datapath and result registers.
// One quotient bit is resolved per clock; results are published only on entry to DONE.
module micro_div_core #(
  parameter int unsigned DVD_W = micro_div_pkg::DVD_W,
  parameter int unsigned DVS_W = micro_div_pkg::DVS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] q_out,
  output logic [DVS_W-1:0] r_out,
  output logic             done,
  output logic             dbz
);
  import micro_div_pkg::*;

  localparam int unsigned CNT_W = $clog2(DVD_W);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W:0]   r_q;
  logic [DVD_W-1:0] q_q;
  logic [DVS_W-1:0] d_q;

  logic             start_rise_c;
  logic             capture_c;
  logic             last_c;
  logic [DVS_W:0]   r_shift_c;
  logic [DVS_W+1:0] trial_c;
  logic             fits_c;
  logic [DVS_W:0]   r_next_c;
  logic [DVD_W-1:0] q_next_c;
  logic             unused_r_msb;

  assign start_rise_c = start & ~start_q;
  assign last_c       = (cnt_q == CNT_W'(DVD_W - 1));

  // Final R is always below D, so the top remainder bit never feeds the next shift.
  assign unused_r_msb = r_q[DVS_W];

  // One restoring step: shift {R,Q} left, subtract D, keep the difference if it did not go negative.
  always_comb begin
    r_shift_c = {r_q[DVS_W-1:0], q_q[DVD_W-1]};
    trial_c   = {1'b0, r_shift_c} - {2'b00, d_q};
    fits_c    = ~trial_c[DVS_W+1];
    r_next_c  = fits_c ? trial_c[DVS_W:0] : r_shift_c;
    q_next_c  = {q_q[DVD_W-2:0], fits_c};
  end

  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise_c) begin
          capture_c = 1'b1;
          state_d   = (divisor == '0) ? DBZ : ITER;
        end
      end
      ITER:    if (last_c) state_d = DONE;
      DBZ:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      q_out <= '0;
      r_out <= '0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else if (capture_c) begin
      q_q  <= dividend;
      d_q  <= divisor;
      r_q  <= '0;
      cnt_q <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else if (state_q == ITER) begin
      r_q   <= r_next_c;
      q_q   <= q_next_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_c) begin
        q_out <= q_next_c;
        r_out <= r_next_c[DVS_W-1:0];
        done  <= 1'b1;
      end
    end else if (state_q == DBZ) begin
      // Q still holds the untouched dividend here.
      q_out <= DVD_W'(DBZ_QUOT);
      r_out <= q_q[DVS_W-1:0];
      dbz   <= 1'b1;
      done  <= 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_micro_div_njp.sv
// TinyTapeout wrapper for the micro_div restoring divider: pin map, rem_sel mux, tie-offs.
// Optional: define MICRO_DIV_START_SYNC_EN to pass start through a 2-flop synchronizer.
module tt_um_micro_div_njp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import micro_div_pkg::*;

  logic             start;
  logic [DVD_W-1:0] q_out;
  logic [DVS_W-1:0] r_out;
  logic             done;
  logic             dbz;
  logic             unused_pins;

`ifdef MICRO_DIV_START_SYNC_EN
  logic [1:0] start_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_sync_q <= 2'b00;
    else        start_sync_q <= {start_sync_q[0], uio_in[4]};
  end

  assign start = start_sync_q[1];
`else
  assign start = uio_in[4];
`endif

  micro_div_core #(
    .DVD_W(DVD_W),
    .DVS_W(DVS_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (ui_in),
    .divisor  (uio_in[3:0]),
    .q_out    (q_out),
    .r_out    (r_out),
    .done     (done),
    .dbz      (dbz)
  );

  assign uo_out      = uio_in[5] ? {4'b0000, r_out} : q_out;
  assign uio_out     = {dbz, done, 6'b00_0000};
  assign uio_oe      = 8'b1100_0000;
  assign unused_pins = &{1'b0, ena, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_micro_div_njp.sv
// Scoreboard bench for tt_um_micro_div_njp: directed cases plus random divisions.
module tb_tt_um_micro_div_njp;

`ifdef MICRO_DIV_START_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [3:0] dvs = 4'd0;
  logic       start = 1'b0;
  logic       rem_sel = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_count = 0;
  logic prev_done = 1'b0;
  exp_t sb_q[$];

  assign uio_in = {2'b00, rem_sel, start, dvs};

  tt_um_micro_div_njp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic exp_t ref_div(input logic [7:0] a, input logic [3:0] d, input int cyc_done);
    exp_t e;
    if (d == 4'd0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
      e.dbz = 1'b1;
    end else begin
      e.q = 8'(int'(a) / int'(d));
      e.r = 4'(int'(a) % int'(d));
      e.dbz = 1'b0;
    end
    e.cyc = cyc_done;
    return e;
  endfunction

  // Monitor: on every rising done, pop the oldest expectation and compare both result views.
  always @(negedge clk) begin
    if (rst_n && uio_out[6] && !prev_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("quotient", uo_out, e.q);
        check("dbz_flag", uio_out[7], e.dbz);
        rem_sel = 1'b1;
        #1;
        check("remainder", uo_out, {4'b0000, e.r});
        rem_sel = 1'b0;
      end
      done_count++;
    end
    prev_done = uio_out[6];
  end

  // Issue one operation; returns at the negedge following E0 (or after the hold, if later).
  task automatic start_op(input logic [7:0] a, input logic [3:0] d, input int hold,
                          output int e0);
    exp_t e;
    @(negedge clk);
    ui_in = a;
    dvs   = d;
    start = 1'b1;
    e0 = cyc + 1 + SYNC_LAT;
    e = ref_div(a, d, e0 + ((d == 4'd0) ? 1 : 8));
    sb_q.push_back(e);
    repeat (hold) @(negedge clk);
    start = 1'b0;
    while (cyc < e0) @(negedge clk);
    if (cyc == e0) check("done_low_after_e0", uio_out[6], 0);
  endtask

  task automatic wait_done(input int n0);
    int budget;
    budget = 40;
    while (done_count == n0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    check("done_seen", done_count - n0, 1);
  endtask

  initial begin : stim
    int e0;
    int n0;
    logic [7:0] a;
    logic [3:0] d;

    #23;
    check("rst_uo_out", uo_out, 0);
    check("rst_uio_out", uio_out, 0);
    check("uio_oe", uio_oe, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_done", uio_out, 0);

    n0 = done_count; start_op(8'd200, 4'd7, 1, e0); wait_done(n0);
    n0 = done_count; start_op(8'd255, 4'd1, 1, e0); wait_done(n0);
    n0 = done_count; start_op(8'd5,   4'd9, 1, e0); wait_done(n0);
    n0 = done_count; start_op(8'd13,  4'd0, 1, e0); wait_done(n0);

    // Mid-operation re-start and operand changes must be ignored; old result stays visible.
    n0 = done_count;
    start_op(8'd100, 4'd3, 1, e0);
    for (int k = 0; k < 20 && done_count == n0; k++) begin
      if (cyc == e0 + 2) begin
        ui_in = 8'd77;
        dvs   = 4'd5;
        start = 1'b1;
      end
      if (cyc == e0 + 3) start = 1'b0;
      if (!uio_out[6]) check("prev_result_held", uo_out, 8'hFF);
      @(negedge clk);
    end
    wait_done(n0);

    // Asynchronous reset in the middle of an operation.
    n0 = done_count;
    start_op(8'd200, 4'd7, 1, e0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", uo_out, 0);
    check("async_rst_uio_out", uio_out, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("post_rst_no_done", done_count - n0, 0);
    check("post_rst_done_low", uio_out[6], 0);

    // Start held high: exactly one operation.
    n0 = done_count;
    start_op(8'd77, 4'd5, 20, e0);
    wait_done(n0);
    repeat (12) @(negedge clk);
    check("held_start_single_op", done_count - n0, 1);

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      d = 4'($urandom_range(0, 15));
      n0 = done_count;
      start_op(a, d, 1, e0);
      wait_done(n0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
